// File: rtl/dual_port_ram_be.sv
// True dual-port byte-enable RAM with selectable read-during-write and optional output register.
// Define DPRAM_COLLISION_CNT_EN to enable the saturating collision counter.
module dual_port_ram_be #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int BYTE_W   = 8,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en_0,
    input  logic [DATA_W/BYTE_W-1:0] we_0,
    input  logic [ADDR_W-1:0]        addr_0,
    input  logic [DATA_W-1:0]        wdata_0,
    output logic [DATA_W-1:0]        rdata_0,
    output logic                     rvalid_0,
    input  logic                     en_1,
    input  logic [DATA_W/BYTE_W-1:0] we_1,
    input  logic [ADDR_W-1:0]        addr_1,
    input  logic [DATA_W-1:0]        wdata_1,
    output logic [DATA_W-1:0]        rdata_1,
    output logic                     rvalid_1,
    output logic                     collision,
    output logic [15:0]              collision_cnt
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [NB-1:0] wl_0;
    logic [NB-1:0] wl_1;
    logic          coll_now;

    assign wl_0 = en_0 ? we_0 : '0;
    assign wl_1 = en_1 ? we_1 : '0;

    assign coll_now = en_0 & en_1 & (addr_0 == addr_1) & (|(we_0 & we_1));

    function automatic logic [DATA_W-1:0] rdw_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     we
    );
        logic [DATA_W-1:0] r;
        r = old_w;
        if (RDW_MODE != 0) begin
            for (int b = 0; b < NB; b++) begin
                if (we[b]) r[b*BYTE_W +: BYTE_W] = new_w[b*BYTE_W +: BYTE_W];
            end
        end
        return r;
    endfunction

    // Port 0 is written last so it owns any overlapping lanes on a collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int b = 0; b < NB; b++) begin
                if (wl_1[b]) mem[addr_1][b*BYTE_W +: BYTE_W] <= wdata_1[b*BYTE_W +: BYTE_W];
                if (wl_0[b]) mem[addr_0][b*BYTE_W +: BYTE_W] <= wdata_0[b*BYTE_W +: BYTE_W];
            end
        end
    end

    logic [DATA_W-1:0] rd0_q;
    logic [DATA_W-1:0] rd1_q;
    logic              rv0_q;
    logic              rv1_q;

    // mem reads here see pre-edge contents, so cross-port reads return old data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd0_q <= '0;
            rd1_q <= '0;
            rv0_q <= 1'b0;
            rv1_q <= 1'b0;
        end else begin
            rv0_q <= en_0;
            rv1_q <= en_1;
            if (en_0) rd0_q <= rdw_merge(mem[addr_0], wdata_0, we_0);
            if (en_1) rd1_q <= rdw_merge(mem[addr_1], wdata_1, we_1);
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] rd0_q2;
            logic [DATA_W-1:0] rd1_q2;
            logic              rv0_q2;
            logic              rv1_q2;

            always_ff @(posedge clk) begin
                if (reset) begin
                    rd0_q2 <= '0;
                    rd1_q2 <= '0;
                    rv0_q2 <= 1'b0;
                    rv1_q2 <= 1'b0;
                end else begin
                    rv0_q2 <= rv0_q;
                    rv1_q2 <= rv1_q;
                    if (rv0_q) rd0_q2 <= rd0_q;
                    if (rv1_q) rd1_q2 <= rd1_q;
                end
            end

            assign rdata_0  = rd0_q2;
            assign rdata_1  = rd1_q2;
            assign rvalid_0 = rv0_q2;
            assign rvalid_1 = rv1_q2;
        end else begin : g_no_out_reg
            assign rdata_0  = rd0_q;
            assign rdata_1  = rd1_q;
            assign rvalid_0 = rv0_q;
            assign rvalid_1 = rv1_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) collision <= 1'b0;
        else       collision <= coll_now;
    end

`ifdef DPRAM_COLLISION_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (coll_now && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign collision_cnt = cnt_q;
`else
    assign collision_cnt = '0;
`endif

endmodule
